// File: rtl/l2_bank_init_ctrl.sv
// L2 bank init controller: sweeps INIT_VALUE over the bank, else passes traffic.
// Define L2_BANK_INIT_CHECK_EN to add a read-back verify pass after each sweep.
module l2_bank_init_ctrl #(
   parameter int unsigned NUM_WORDS = 32768,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS),
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [ADDR_WIDTH-1:0]   add_i,
   input  logic                    wen_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    init_start_i,
   output logic                    init_busy_o,
   output logic                    init_done_o,
   output logic                    init_err_o,
   output logic [ADDR_WIDTH-1:0]   init_err_addr_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SWEEP_WR,
      SWEEP_RD,
      SWEEP_CHK
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  boot_q, boot_d;
   logic                  done_q, done_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         boot_q  <= INIT_ON_RESET;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         boot_q  <= boot_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      boot_d      = boot_q;
      done_d      = done_q;
      gnt_o       = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = add_i;
      mem_wdata_o = wdata_i;
      mem_be_o    = be_i;
      unique case (state_q)
         IDLE: begin
            gnt_o     = req_i;
            mem_req_o = req_i;
            mem_we_o  = ~wen_i;
            if (init_start_i || boot_q) begin
               state_d = SWEEP_WR;
               cnt_d   = '0;
               boot_d  = 1'b0;
            end
         end
         SWEEP_WR: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = cnt_q;
            mem_wdata_o = INIT_VALUE;
            mem_be_o    = '1;
            if (cnt_q == LAST) begin
               cnt_d = '0;
`ifdef L2_BANK_INIT_CHECK_EN
               state_d = SWEEP_RD;
`else
               state_d = IDLE;
               done_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef L2_BANK_INIT_CHECK_EN
         SWEEP_RD: begin
            mem_req_o  = 1'b1;
            mem_addr_o = cnt_q;
            mem_be_o   = '1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = SWEEP_CHK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SWEEP_CHK: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
`endif
         default: state_d = IDLE;
      endcase
      // nothing reaches the SRAM or the interconnect while reset is held
      if (rst_i) begin
         gnt_o     = 1'b0;
         mem_req_o = 1'b0;
      end
   end

   assign rdata_o     = mem_rdata_i;
   assign init_busy_o = (state_q != IDLE);
   assign init_done_o = done_q;

`ifdef L2_BANK_INIT_CHECK_EN
   logic                  chk_q;
   logic [ADDR_WIDTH-1:0] chk_addr_q;
   logic                  err_q;
   logic [ADDR_WIDTH-1:0] err_addr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         chk_q      <= 1'b0;
         chk_addr_q <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         chk_q      <= (state_q == SWEEP_RD);
         chk_addr_q <= cnt_q;
         if (chk_q && (mem_rdata_i != INIT_VALUE)) begin
            err_q <= 1'b1;
            if (!err_q) err_addr_q <= chk_addr_q;
         end
      end
   end

   assign init_err_o      = err_q;
   assign init_err_addr_o = err_addr_q;
`else
   assign init_err_o      = 1'b0;
   assign init_err_addr_o = '0;
`endif

endmodule

// File: tb/tb_l2_bank_init_ctrl.sv
// Randomized bench for l2_bank_init_ctrl with a sweep-level reference model
// and a byte-accurate scoreboard of the bank contents.
module tb_l2_bank_init_ctrl;

   localparam int N = 12;
   localparam int AW = $clog2(N);
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam logic [DW-1:0] INIT = 32'hDEAD_BEEF;
`ifdef L2_BANK_INIT_CHECK_EN
   localparam int L = 2 * N + 1;
`else
   localparam int L = N;
`endif

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_i = 1'b0;
   logic          gnt_o;
   logic [AW-1:0] add_i = '0;
   logic          wen_i = 1'b1;
   logic [DW-1:0] wdata_i = '0;
   logic [BW-1:0] be_i = '0;
   logic [DW-1:0] rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [BW-1:0] mem_be_o;
   logic [DW-1:0] mem_rdata_i;
   logic          init_start_i = 1'b0;
   logic          init_busy_o;
   logic          init_done_o;
   logic          init_err_o;
   logic [AW-1:0] init_err_addr_o;

   int n_tests = 0;
   int n_fail = 0;

   l2_bank_init_ctrl #(
      .NUM_WORDS    (N),
      .DATA_WIDTH   (DW),
      .INIT_VALUE   (INIT),
      .INIT_ON_RESET(1'b1)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .gnt_o          (gnt_o),
      .add_i          (add_i),
      .wen_i          (wen_i),
      .wdata_i        (wdata_i),
      .be_i           (be_i),
      .rdata_o        (rdata_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_be_o       (mem_be_o),
      .mem_rdata_i    (mem_rdata_i),
      .init_start_i   (init_start_i),
      .init_busy_o    (init_busy_o),
      .init_done_o    (init_done_o),
      .init_err_o     (init_err_o),
      .init_err_addr_o(init_err_addr_o)
   );

   always #5 clk = ~clk;

   // SRAM cut with 1-cycle read latency; verify-pass reads of 3 and 7 are corrupted
   logic [DW-1:0] sram [N];
   logic [DW-1:0] sram_rd = '0;
   bit            m_swrd = 1'b0;
   assign mem_rdata_i = sram_rd;

   always @(posedge clk) begin
      if (mem_req_o && int'(mem_addr_o) < N) begin
         if (mem_we_o) begin
            for (int b = 0; b < BW; b++)
               if (mem_be_o[b])
                  sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
`ifdef L2_BANK_INIT_CHECK_EN
            if (m_swrd && (mem_addr_o == 3 || mem_addr_o == 7))
               sram_rd <= sram[mem_addr_o] ^ 32'h0000_0100;
            else
               sram_rd <= sram[mem_addr_o];
`else
            sram_rd <= sram[mem_addr_o];
`endif
         end
      end
   end

   // reference model: sweep position counted in cycles, bank image in ref_mem
   logic [DW-1:0] ref_mem [N];
   bit            m_busy = 1'b0;
   bit            m_done = 1'b0;
   bit            m_boot = 1'b1;
   bit            m_err = 1'b0;
   int            m_err_addr = 0;
   int            m_pos = 0;
   bit            m_rd_vld = 1'b0;
   logic [DW-1:0] m_rd = '0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit st, input int mode);
      bit            rq;
      bit            wn;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [BW-1:0] be;
      bit            e_gnt, e_req, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic [BW-1:0] e_be;
      rq = (mode == 1) || (mode == 2 && $urandom_range(1) == 1);
      wn = $urandom_range(1) == 1;
      a  = AW'($urandom_range(N - 1));
      wd = $urandom;
      be = BW'($urandom);
      @(posedge clk);
      #1;
      rst_i = r;
      init_start_i = st;
      req_i = rq;
      wen_i = wn;
      add_i = a;
      wdata_i = wd;
      be_i = be;
      e_gnt = 0; e_req = 0; e_we = 0;
      e_addr = a; e_wd = wd; e_be = be;
      m_swrd = 0;
      if (r) begin
         e_req = 0;
      end else if (m_busy) begin
         if (m_pos < N) begin
            e_req = 1; e_we = 1;
            e_addr = AW'(m_pos); e_wd = INIT; e_be = '1;
         end else if (m_pos < 2 * N) begin
            e_req = 1;
            e_addr = AW'(m_pos - N);
            m_swrd = 1;
         end
      end else begin
         e_gnt = rq; e_req = rq; e_we = ~wn;
      end
      @(negedge clk);
      check("ctl", {gnt_o, mem_req_o, init_busy_o, init_done_o},
            {e_gnt, e_req, m_busy, m_done});
      if (e_req) begin
         check("we", mem_we_o, e_we);
         check("addr", mem_addr_o, e_addr);
         if (e_we) begin
            check("wdata", mem_wdata_o, e_wd);
            check("be", mem_be_o, e_be);
         end
      end
      if (m_rd_vld) check("rdata", rdata_o, m_rd);
`ifdef L2_BANK_INIT_CHECK_EN
      if (!m_busy)
         check("err", {init_err_o, init_err_addr_o}, {m_err, AW'(m_err_addr)});
`else
      check("err", {init_err_o, init_err_addr_o}, '0);
`endif
      m_rd_vld = 0;
      if (r) begin
         m_busy = 0; m_done = 0; m_pos = 0; m_boot = 1;
         m_err = 0; m_err_addr = 0;
      end else if (m_busy) begin
         if (m_pos < N) ref_mem[m_pos] = INIT;
         m_pos++;
         if (m_pos == L) begin
            m_busy = 0;
            m_done = 1;
`ifdef L2_BANK_INIT_CHECK_EN
            m_err = 1;
            m_err_addr = 3;
`endif
         end
      end else begin
         if (rq && wn) begin
            m_rd = ref_mem[a];
            m_rd_vld = 1;
         end else if (rq) begin
            for (int b = 0; b < BW; b++)
               if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
         end
         if (st || m_boot) begin
            m_busy = 1; m_pos = 0; m_boot = 0;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         sram[i] = '0;
         ref_mem[i] = '0;
      end
      repeat (3) step(1, 0, 1);
      repeat (L + 4) step(0, 0, 1);
      repeat (30) step(0, 0, 2);
      step(0, 1, 2);
      for (int i = 0; i < L; i++) step(0, i == 7, 1);
      repeat (5) step(0, 0, 2);
      step(0, 1, 0);
      repeat (9) step(0, 0, 2);
      step(1, 0, 1);
      step(1, 0, 1);
      repeat (L + 5) step(0, 0, 2);
      repeat (600)
         step($urandom_range(99) == 0, $urandom_range(19) == 0, 2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/l2_bank_init_ctrl.md
Name: l2_bank_init_ctrl

Overview:
Per-bank controller between one tcdm_interconnect output port and one L2 SRAM cut (tc_sram, 1-cycle read latency). After reset or on software request it sequences a full-bank initialisation sweep, writing INIT_VALUE to every word. During the sweep it withholds grant from the interconnect. Outside a sweep it passes interconnect traffic straight through to the SRAM. One instance per L2 bank.

Parameters:
NUM_WORDS, 32768, words in the bank; any value >= 2, not restricted to a power of 2
ADDR_WIDTH, $clog2(NUM_WORDS), bank word-address width
DATA_WIDTH, 32, word width
INIT_VALUE, '0, DATA_WIDTH pattern written during the sweep
INIT_ON_RESET, 1, 1: start a sweep automatically on the first cycle after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  1  interconnect request
gnt_o  out  1  grant to interconnect
add_i  in  ADDR_WIDTH  word address
wen_i  in  1  1=read, 0=write
wdata_i  in  DATA_WIDTH  write data
be_i  in  DATA_WIDTH/8  byte enables
rdata_o  out  DATA_WIDTH  read data, forwarded from mem_rdata_i
mem_req_o  out  1  SRAM request
mem_we_o  out  1  SRAM write enable, active-high
mem_addr_o  out  ADDR_WIDTH  SRAM address
mem_wdata_o  out  DATA_WIDTH  SRAM write data
mem_be_o  out  DATA_WIDTH/8  SRAM byte enables
mem_rdata_i  in  DATA_WIDTH  SRAM read data
init_start_i  in  1  single-cycle pulse that starts a sweep
init_busy_o  out  1  sweep in progress
init_done_o  out  1  sticky; at least one sweep has completed
init_err_o  out  1  sticky read-back mismatch flag (optional feature)
init_err_addr_o  out  ADDR_WIDTH  address of first mismatch (optional feature)

Behaviour:
- FSM states: IDLE, SWEEP_WR, SWEEP_RD (feature only), SWEEP_CHK (feature only).
- Reset:
  - State becomes IDLE, counter cnt=0.
  - init_busy_o=0, init_done_o=0, init_err_o=0, init_err_addr_o=0, gnt_o=0, mem_req_o=0.
  - If INIT_ON_RESET=1, the FSM enters SWEEP_WR on the first cycle after rst_i deasserts.
- Reset asserted mid-sweep: the sweep aborts immediately and all flags clear. Partial memory contents are undefined.
- IDLE (pass-through):
  - gnt_o = req_i, mem_req_o = req_i, mem_we_o = ~wen_i.
  - addr, wdata and be are passed through combinationally.
  - Read data is valid on rdata_o one cycle after grant.
  - init_start_i in IDLE moves the FSM to SWEEP_WR next cycle. A request granted in that same cycle completes normally.
- SWEEP_WR:
  - gnt_o=0 regardless of req_i.
  - Each cycle drives mem_req_o=1, mem_we_o=1, mem_addr_o=cnt, mem_wdata_o=INIT_VALUE, mem_be_o all ones.
  - cnt increments every cycle. After writing NUM_WORDS-1, cnt clears to 0.
  - Without the feature, the FSM then goes to IDLE and sets init_done_o.
  - A write sweep lasts exactly NUM_WORDS cycles.
- init_busy_o=1 in every state other than IDLE.
- init_start_i while busy is ignored: no restart, no queueing.
- init_start_i together with a pending req_i in IDLE: the request is granted that cycle, then the sweep starts.
- init_done_o stays 1 through later sweeps until reset.
- rdata_o equals mem_rdata_i at all times. Its value is meaningful only one cycle after an interconnect grant.

Optional Feature:
Macro L2_BANK_INIT_CHECK_EN.
- Defined: SWEEP_WR exits to SWEEP_RD instead of IDLE.
  - SWEEP_RD issues reads (mem_we_o=0) for addresses 0..NUM_WORDS-1, one per cycle.
  - SWEEP_CHK is the single trailing cycle after the last read.
  - Each cycle after a read, mem_rdata_i is compared with INIT_VALUE. On mismatch, init_err_o is set (sticky). On the first mismatch only, init_err_addr_o captures the address of that read.
  - After SWEEP_CHK the FSM returns to IDLE and init_done_o is set.
  - Total sweep length is 2*NUM_WORDS+1 cycles. gnt_o=0 throughout.
  - A new sweep does not clear init_err_o; only reset does.
- Undefined: no read-back pass; init_err_o and init_err_addr_o are tied to 0.

Test Plan:
1. NUM_WORDS=16, INIT_ON_RESET=1, INIT_VALUE=32'hDEAD_BEEF; release reset -> 16 consecutive writes at addresses 0..15; init_done_o rises on cycle 17; a read of address 5 returns 32'hDEADBEEF one cycle after grant.
2. NUM_WORDS=12 (not a power of 2) -> addresses 0..11 only; cnt wraps to 0; address 12 is never driven.
3. req_i held high throughout a sweep -> gnt_o=0 every sweep cycle; the first grant occurs in the first IDLE cycle; no SRAM access is lost or duplicated.
4. init_start_i pulsed at sweep cycle 7 -> ignored; the sweep ends at NUM_WORDS cycles.
5. rst_i asserted at sweep cycle 9 -> next cycle init_busy_o=0, init_done_o=0, mem_req_o=0; with INIT_ON_RESET=1 the sweep restarts at address 0.
6. With L2_BANK_INIT_CHECK_EN defined, memory model corrupts address 3 and address 7 -> init_err_o=1, init_err_addr_o=3; sweep length is 2*NUM_WORDS+1 cycles.
